// File: rtl/ram_access_arbiter.sv
// Single-port 16x8 RAM shared between the CPU core and a host loader port.
// Fixed CPU priority with host anti-starvation, a host lock, and a sequenced clear sweep.
module ram_access_arbiter #(
    parameter int DEPTH        = 16,
    parameter int AW           = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [7:0]    cpu_wdata_i,
    output logic          cpu_gnt_o,
    output logic          cpu_rvalid_o,
    output logic [7:0]    cpu_rdata_o,
    input  logic          host_req_i,
    input  logic          host_we_i,
    input  logic [AW-1:0] host_addr_i,
    input  logic [7:0]    host_wdata_i,
    output logic          host_gnt_o,
    output logic          host_rvalid_o,
    output logic [7:0]    host_rdata_o,
    input  logic          host_lock_i,
    output logic          cpu_stall_o,
    input  logic          clr_start_i,
    output logic          clr_busy_o
);

    typedef enum logic [1:0] {IDLE, ACCESS, CLEAR} state_e;
    typedef enum logic {OWN_CPU, OWN_HOST} owner_e;

    localparam logic [3:0]    STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [AW-1:0] CLR_LAST   = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [3:0]    starve_q, starve_d;
    logic [AW-1:0] clr_ptr_q, clr_ptr_d;
    logic          host_win, cpu_win;

    logic [7:0]    mem_q [DEPTH];
    logic          cpu_rvalid_q, host_rvalid_q;
    logic [7:0]    cpu_rdata_q, host_rdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            owner_q   <= OWN_CPU;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            starve_q  <= '0;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            starve_q  <= starve_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Host wins when locked, when starved, or when the CPU is not asking; a lock blocks the CPU outright.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        starve_d  = starve_q;
        clr_ptr_d = clr_ptr_q;
        host_win  = 1'b0;
        cpu_win   = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_start_i) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                end else begin
                    host_win = host_req_i &&
                               (host_lock_i || !cpu_req_i || (starve_q == STARVE_MAX));
                    cpu_win  = cpu_req_i && !host_lock_i && !host_win;
                end
                if (!host_req_i || host_win) begin
                    starve_d = '0;
                end else if (cpu_win && (starve_q != STARVE_MAX)) begin
                    starve_d = starve_q + 4'd1;
                end
                if (host_win) begin
                    state_d = ACCESS;
                    owner_d = OWN_HOST;
                    we_d    = host_we_i;
                    addr_d  = host_addr_i;
                    wdata_d = host_wdata_i;
                end else if (cpu_win) begin
                    state_d = ACCESS;
                    owner_d = OWN_CPU;
                    we_d    = cpu_we_i;
                    addr_d  = cpu_addr_i;
                    wdata_d = cpu_wdata_i;
                end
            end
            ACCESS: begin
                state_d = IDLE;
            end
            CLEAR: begin
                if (clr_ptr_q == CLR_LAST) begin
                    state_d   = IDLE;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cpu_gnt_o  = 1'b0;
        host_gnt_o = 1'b0;
        clr_busy_o = 1'b0;
        case (state_q)
            ACCESS: begin
                cpu_gnt_o  = (owner_q == OWN_CPU);
                host_gnt_o = (owner_q == OWN_HOST);
            end
            CLEAR:   clr_busy_o = 1'b1;
            default: ;
        endcase
        cpu_stall_o = host_lock_i | clr_busy_o;
    end

    // RAM is held in flops so that reset can zero every entry at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            cpu_rvalid_q  <= 1'b0;
            host_rvalid_q <= 1'b0;
            cpu_rdata_q   <= '0;
            host_rdata_q  <= '0;
        end else begin
            cpu_rvalid_q  <= 1'b0;
            host_rvalid_q <= 1'b0;
            if (state_q == ACCESS) begin
                if (we_q) begin
                    mem_q[addr_q] <= wdata_q;
                end else if (owner_q == OWN_CPU) begin
                    cpu_rvalid_q <= 1'b1;
                    cpu_rdata_q  <= mem_q[addr_q];
                end else begin
                    host_rvalid_q <= 1'b1;
                    host_rdata_q  <= mem_q[addr_q];
                end
            end else if (state_q == CLEAR) begin
                mem_q[clr_ptr_q] <= '0;
            end
        end
    end

    assign cpu_rvalid_o  = cpu_rvalid_q;
    assign cpu_rdata_o   = cpu_rdata_q;
    assign host_rvalid_o = host_rvalid_q;
    assign host_rdata_o  = host_rdata_q;

endmodule
